// File: rtl/branch_resolve_predictor.sv
// ---------------------------------------------------------------------------
// branch_resolve_predictor
//
// Supplies and closes the branch prediction carried through the ID/EX register.
//   ID side : per-PC 2-bit saturating-counter lookup produces id_predTaken_o,
//             which is captured into ID/EX alongside the instruction.
//   EX side : consumes the resolved branch, trains the table, requests the
//             IF/ID + ID/EX flush on a mispredict, selects the corrected PC
//             and keeps saturating branch/mispredict statistics.
//
// Ports
//   clk_i            in   1          clock, all state updates on posedge
//   rst_i            in   1          synchronous reset, active-high
//   id_pc_i          in   32         PC of instruction in ID (lookup address)
//   id_predTaken_o   out  1          prediction for the ID instruction
//   ex_branch_i      in   1          a valid branch is resolving in EX
//   ex_predTaken_i   in   1          prediction that was acted on for it
//   ex_taken_i       in   1          actual outcome computed in EX
//   ex_pc_i          in   32         PC of the resolving branch (update address)
//   ex_pc_branch_i   in   32         taken target
//   ex_pc_default_i  in   32         fall-through PC
//   mispredict_o     out  1          flush request / PC redirect select
//   pc_correct_o     out  32         redirect PC, valid when mispredict_o = 1
//   branch_cnt_o     out  CNT_WIDTH  branches resolved since reset
//   mispredict_cnt_o out  CNT_WIDTH  mispredicts since reset
// ---------------------------------------------------------------------------
module branch_resolve_predictor #(
    parameter int          IDX_BITS   = 4,
    parameter logic [1:0]  INIT_STATE = 2'b10,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          id_pc_i,
    output logic                 id_predTaken_o,
    input  logic                 ex_branch_i,
    input  logic                 ex_predTaken_i,
    input  logic                 ex_taken_i,
    input  logic [31:0]          ex_pc_i,
    input  logic [31:0]          ex_pc_branch_i,
    input  logic [31:0]          ex_pc_default_i,
    output logic                 mispredict_o,
    output logic [31:0]          pc_correct_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Next state of a 2-bit saturating counter given the branch outcome.
    function automatic logic [1:0] sat_counter_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        end else begin
            nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
        end
        return nxt;
    endfunction

    // Statistics increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_stat_inc(input logic [CNT_WIDTH-1:0] cur, input logic inc);
        logic [CNT_WIDTH-1:0] nxt;
        if (inc && (cur != {CNT_WIDTH{1'b1}})) begin
            nxt = cur + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [1:0]           r_table [ENTRIES];
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispredict_cnt;

    logic [IDX_BITS-1:0]  w_id_idx;
    logic [IDX_BITS-1:0]  w_ex_idx;
    logic                 w_mispredict;
    logic [31:0]          w_pc_correct;

    // Word-aligned PCs: bits [1:0] and everything above the index are not
    // used, so aliasing PCs share one counter (untagged table).
    assign w_id_idx = id_pc_i[IDX_BITS+1:2];
    assign w_ex_idx = ex_pc_i[IDX_BITS+1:2];

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{id_pc_i[31:IDX_BITS+2], id_pc_i[1:0],
                                ex_pc_i[31:IDX_BITS+2], ex_pc_i[1:0]};

    // Resolve: compare against the prediction carried down the pipe, not a
    // fresh table read, since the entry may have been retrained meanwhile.
    always_comb begin
        w_mispredict = 1'b0;
        w_pc_correct = ex_pc_default_i;
        if (ex_branch_i && (ex_taken_i != ex_predTaken_i)) begin
            w_mispredict = 1'b1;
        end else begin
            w_mispredict = 1'b0;
        end
        if (ex_taken_i) begin
            w_pc_correct = ex_pc_branch_i;
        end else begin
            w_pc_correct = ex_pc_default_i;
        end
    end

    // Counter table training and statistics; reset wins over any update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= INIT_STATE;
            end
            r_branch_cnt     <= {CNT_WIDTH{1'b0}};
            r_mispredict_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (ex_branch_i) begin
                r_table[w_ex_idx] <= sat_counter_next(r_table[w_ex_idx], ex_taken_i);
            end
            r_branch_cnt     <= sat_stat_inc(r_branch_cnt, ex_branch_i);
            r_mispredict_cnt <= sat_stat_inc(r_mispredict_cnt, w_mispredict);
        end
    end

    // Lookup returns the pre-update value on a same-cycle index collision.
    assign id_predTaken_o   = r_table[w_id_idx][1];
    assign mispredict_o     = w_mispredict;
    assign pc_correct_o     = w_pc_correct;
    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_predictor
//
// Directed vectors against branch_resolve_predictor (IDX_BITS=4,
// INIT_STATE=2'b10, CNT_WIDTH=4 so statistics saturation is reachable).
// ---------------------------------------------------------------------------
module tb_branch_resolve_predictor;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic [31:0] id_pc_s;
    logic        id_pred_s;
    logic        ex_branch_s;
    logic        ex_pred_s;
    logic        ex_taken_s;
    logic [31:0] ex_pc_s;
    logic [31:0] ex_pc_branch_s;
    logic [31:0] ex_pc_default_s;
    logic        mispredict_s;
    logic [31:0] pc_correct_s;
    logic [3:0]  branch_cnt_s;
    logic [3:0]  mispredict_cnt_s;

    int n_vec_r = 0;
    int n_err_r = 0;

    branch_resolve_predictor #(
        .IDX_BITS   (4),
        .INIT_STATE (2'b10),
        .CNT_WIDTH  (4)
    ) dut (
        .clk_i            (clk_s),
        .rst_i            (rst_s),
        .id_pc_i          (id_pc_s),
        .id_predTaken_o   (id_pred_s),
        .ex_branch_i      (ex_branch_s),
        .ex_predTaken_i   (ex_pred_s),
        .ex_taken_i       (ex_taken_s),
        .ex_pc_i          (ex_pc_s),
        .ex_pc_branch_i   (ex_pc_branch_s),
        .ex_pc_default_i  (ex_pc_default_s),
        .mispredict_o     (mispredict_s),
        .pc_correct_o     (pc_correct_s),
        .branch_cnt_o     (branch_cnt_s),
        .mispredict_cnt_o (mispredict_cnt_s)
    );

    // Free-running clock, period 10.
    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec_r++;
        if (got !== exp) begin
            n_err_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle just past the edge before sampling.
    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Present a branch resolve in EX and clock it in.
    task automatic resolve(input logic [31:0] pc, input logic pred, input logic taken);
        ex_branch_s = 1'b1;
        ex_pc_s     = pc;
        ex_pred_s   = pred;
        ex_taken_s  = taken;
        tick();
        ex_branch_s = 1'b0;
    endtask

    initial begin
        rst_s           = 1'b1;
        id_pc_s         = 32'h0000_000C;
        ex_branch_s     = 1'b0;
        ex_pred_s       = 1'b0;
        ex_taken_s      = 1'b0;
        ex_pc_s         = 32'h0000_0000;
        ex_pc_branch_s  = 32'h0000_0100;
        ex_pc_default_s = 32'h0000_0010;
        tick();
        tick();
        rst_s = 1'b0;

        // Reset state
        check_val("rst_pred", {31'd0, id_pred_s}, 32'd1);
        check_val("rst_misp", {31'd0, mispredict_s}, 32'd0);
        check_val("rst_bcnt", {28'd0, branch_cnt_s}, 32'd0);
        check_val("rst_mcnt", {28'd0, mispredict_cnt_s}, 32'd0);

        // Predicted taken, actually not taken at 0x0C
        ex_branch_s = 1'b1; ex_pc_s = 32'h0000_000C; ex_pred_s = 1'b1; ex_taken_s = 1'b0;
        #1;
        check_val("t2_misp", {31'd0, mispredict_s}, 32'd1);
        check_val("t2_pcc", pc_correct_s, 32'h0000_0010);
        tick();
        ex_branch_s = 1'b0;
        check_val("t2_pred", {31'd0, id_pred_s}, 32'd0);
        check_val("t2_bcnt", {28'd0, branch_cnt_s}, 32'd1);
        check_val("t2_mcnt", {28'd0, mispredict_cnt_s}, 32'd1);

        // Bubbles never train or count, even with pred != taken
        ex_pc_s = 32'h0000_000C; ex_pred_s = 1'b1; ex_taken_s = 1'b1;
        #1;
        check_val("bub_misp", {31'd0, mispredict_s}, 32'd0);
        tick();
        tick();
        check_val("bub_pred", {31'd0, id_pred_s}, 32'd0);
        check_val("bub_bcnt", {28'd0, branch_cnt_s}, 32'd1);

        // Drive entry 3 to 00, then four taken resolves: 01,10,11,11
        resolve(32'h0000_000C, 1'b0, 1'b0);
        check_val("t3_pred00", {31'd0, id_pred_s}, 32'd0);
        ex_branch_s = 1'b1; ex_pc_s = 32'h0000_000C; ex_pred_s = 1'b1; ex_taken_s = 1'b1;
        #1;
        check_val("t3_misp", {31'd0, mispredict_s}, 32'd0);
        check_val("t3_pcc", pc_correct_s, 32'h0000_0100);
        tick();
        check_val("t3_pred01", {31'd0, id_pred_s}, 32'd0);
        tick();
        check_val("t3_pred10", {31'd0, id_pred_s}, 32'd1);
        tick();
        check_val("t3_pred11", {31'd0, id_pred_s}, 32'd1);
        tick();
        check_val("t3_pred11s", {31'd0, id_pred_s}, 32'd1);
        ex_branch_s = 1'b0;
        // Saturated at 11: one not-taken leaves 10, still predicts taken
        resolve(32'h0000_000C, 1'b1, 1'b0);
        check_val("t3_sat_pred", {31'd0, id_pred_s}, 32'd1);
        check_val("t3_bcnt", {28'd0, branch_cnt_s}, 32'd7);
        check_val("t3_mcnt", {28'd0, mispredict_cnt_s}, 32'd2);

        // Same-index lookup and update at 0x20 (entry 8, 10 -> 01 first)
        resolve(32'h0000_0020, 1'b1, 1'b0);
        id_pc_s = 32'h0000_0020;
        ex_branch_s = 1'b1; ex_pc_s = 32'h0000_0020; ex_pred_s = 1'b0; ex_taken_s = 1'b1;
        #1;
        check_val("t4_pred_now", {31'd0, id_pred_s}, 32'd0);
        check_val("t4_misp", {31'd0, mispredict_s}, 32'd1);
        check_val("t4_pcc", pc_correct_s, 32'h0000_0100);
        tick();
        ex_branch_s = 1'b0;
        check_val("t4_pred_next", {31'd0, id_pred_s}, 32'd1);
        check_val("t4_bcnt", {28'd0, branch_cnt_s}, 32'd9);
        check_val("t4_mcnt", {28'd0, mispredict_cnt_s}, 32'd4);

        // Train entry 3 to 00, then reset with a same-cycle update
        id_pc_s = 32'h0000_000C;
        resolve(32'h0000_000C, 1'b1, 1'b0);
        resolve(32'h0000_000C, 1'b0, 1'b0);
        check_val("t5_pred_tr", {31'd0, id_pred_s}, 32'd0);
        rst_s = 1'b1;
        resolve(32'h0000_000C, 1'b1, 1'b0);
        rst_s = 1'b0;
        check_val("t5_pred_rst", {31'd0, id_pred_s}, 32'd1);
        check_val("t5_bcnt", {28'd0, branch_cnt_s}, 32'd0);
        check_val("t5_mcnt", {28'd0, mispredict_cnt_s}, 32'd0);

        // 20 mispredicting branches at 0x4C (aliases 0x0C): stats stick at 15
        for (int i = 0; i < 20; i++) begin
            resolve(32'h0000_004C, 1'b1, 1'b0);
            if (i == 14) begin
                check_val("t6_bcnt15", {28'd0, branch_cnt_s}, 32'd15);
            end
        end
        check_val("t6_bcnt", {28'd0, branch_cnt_s}, 32'd15);
        check_val("t6_mcnt", {28'd0, mispredict_cnt_s}, 32'd15);
        check_val("t6_alias", {31'd0, id_pred_s}, 32'd0);
        id_pc_s = 32'h0000_000F;
        #1;
        check_val("t6_lowbits", {31'd0, id_pred_s}, 32'd0);
        id_pc_s = 32'h0000_0010;
        #1;
        check_val("t6_other", {31'd0, id_pred_s}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec_r, n_err_r);
        $finish;
    end

endmodule
